pic_irq_resolver: RTL and testbench

Parametrised interrupt core for the PIC: N request inputs with edge or level capture, interrupt request (IRR), in-service (ISR) and mask handling, and fully-nested or automatic-rotation priority resolution. It also runs the two-pulse INTA acknowledge sequence and the end-of-interrupt (EOI) command. It sits between the IR pins and the control logic / data-bus buffer, and replaces the separate IRR and priority-resolver blocks.

---
 rtl/pic_irq_resolver_if.sv | 30 +++
 rtl/pic_irq_resolver.sv | 158 +++++++++++++++
 tb/tb_pic_irq_resolver.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pic_irq_resolver_if.sv
// Bus between the PIC control logic (master) and the interrupt core (slave):
// raw requests, configuration, INTA/EOI strobes and the resolver results.
interface pic_irq_if #(
    parameter int NUM_IRQ = 8,
    parameter int IDX_W   = $clog2(NUM_IRQ)
);
    logic [NUM_IRQ-1:0] ir;
    logic               level_mode;
    logic [NUM_IRQ-1:0] mask;
    logic               rotate_mode;
    logic               inta;
    logic               eoi;
    logic               eoi_specific;
    logic [IDX_W-1:0]   eoi_idx;
    logic               int_out;
    logic [IDX_W-1:0]   vector_idx;
    logic               vector_valid;
    logic [NUM_IRQ-1:0] irr;
    logic [NUM_IRQ-1:0] isr;

    modport master (
        output ir, level_mode, mask, rotate_mode, inta, eoi, eoi_specific, eoi_idx,
        input  int_out, vector_idx, vector_valid, irr, isr
    );

    modport slave (
        input  ir, level_mode, mask, rotate_mode, inta, eoi, eoi_specific, eoi_idx,
        output int_out, vector_idx, vector_valid, irr, isr
    );
endinterface

// File: rtl/pic_irq_resolver.sv
// PIC interrupt core: edge/level request capture, IRR/ISR/mask handling,
// fully-nested or rotating priority, two-pulse INTA sequence and EOI.
// Optional feature macro: PIC_AEOI_EN (automatic EOI when entering ACK2).
module pic_irq_resolver #(
    parameter int NUM_IRQ = 8,
    parameter int IDX_W   = $clog2(NUM_IRQ)
) (
    input  logic     clk,
    input  logic     reset,
    pic_irq_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK1 = 2'd1,
        ACK2 = 2'd2
    } state_t;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
        logic [IDX_W-1:0] rank;
    } pick_t;

    state_t             state;
    logic [NUM_IRQ-1:0] prev_ir;
    logic [NUM_IRQ-1:0] irr_q;
    logic [NUM_IRQ-1:0] isr_q;
    logic [IDX_W-1:0]   low_prio;
    logic [IDX_W-1:0]   vector_q;
    logic               vector_valid_q;
    logic               int_q;

    logic [NUM_IRQ-1:0] irr_n;
    logic [NUM_IRQ-1:0] isr_n;
    logic [IDX_W-1:0]   low_n;
    logic [NUM_IRQ-1:0] ack_clr;
    logic               ack_take;
    logic               aeoi_fire;
    logic               int_n;
    pick_t              win;
    pick_t              top;

    // Highest-priority set bit of vec, scanning from low+1 with modulo wrap;
    // rank is the rotated distance (0 = highest priority).
    function automatic pick_t pick_top(input logic [NUM_IRQ-1:0] vec,
                                       input logic [IDX_W-1:0]   low);
        pick_t            p;
        int unsigned      s;
        logic [IDX_W-1:0] c;
        p = '0;
        for (int unsigned d = 0; d < NUM_IRQ; d++) begin
            s = int'(low) + 1 + d;
            if (s >= NUM_IRQ) s = s - NUM_IRQ;
            c = IDX_W'(s);
            if (!p.found && vec[c]) begin
                p.found = 1'b1;
                p.idx   = c;
                p.rank  = IDX_W'(d);
            end
        end
        return p;
    endfunction

    assign win      = pick_top(irr_q & ~bus.mask, low_prio);
    assign top      = pick_top(isr_q, low_prio);
    assign ack_take = (state == IDLE) && bus.inta;

`ifdef PIC_AEOI_EN
    logic ack_real;
    // Auto-EOI only for a real acknowledge; a spurious INTA owns no ISR bit.
    assign aeoi_fire = (state == ACK1) && bus.inta && ack_real;
`else
    assign aeoi_fire = 1'b0;
`endif

    // Next IRR/ISR/priority: clears are applied first so that the ACK1 set wins.
    always_comb begin
        ack_clr = '0;
        if (ack_take && win.found) ack_clr[win.idx] = 1'b1;

        if (bus.level_mode)
            irr_n = bus.ir & ~ack_clr;
        else
            irr_n = bus.ir & (irr_q | ~prev_ir) & ~ack_clr;

        isr_n = isr_q;
        low_n = low_prio;
        if (aeoi_fire) begin
            isr_n[vector_q] = 1'b0;
            if (bus.rotate_mode) low_n = vector_q;
        end
        if (bus.eoi) begin
            if (bus.eoi_specific) begin
                if (int'(bus.eoi_idx) < NUM_IRQ) isr_n[bus.eoi_idx] = 1'b0;
            end else if (top.found) begin
                isr_n[top.idx] = 1'b0;
                if (bus.rotate_mode) low_n = top.idx;
            end
        end
        isr_n = isr_n | ack_clr;

        int_n = win.found && ((isr_q == '0) || (win.rank < top.rank));
    end

    // Register state, FSM and all outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            prev_ir        <= '0;
            irr_q          <= '0;
            isr_q          <= '0;
            low_prio       <= IDX_W'(NUM_IRQ - 1);
            vector_q       <= '0;
            vector_valid_q <= 1'b0;
            int_q          <= 1'b0;
`ifdef PIC_AEOI_EN
            ack_real       <= 1'b0;
`endif
        end else begin
            prev_ir  <= bus.ir;
            irr_q    <= irr_n;
            isr_q    <= isr_n;
            low_prio <= low_n;
            int_q    <= int_n;
            case (state)
                IDLE: begin
                    if (bus.inta) begin
                        state          <= ACK1;
                        vector_valid_q <= 1'b1;
                        vector_q       <= win.found ? win.idx : IDX_W'(NUM_IRQ - 1);
`ifdef PIC_AEOI_EN
                        ack_real       <= win.found;
`endif
                    end
                end
                ACK1: begin
                    if (bus.inta) state <= ACK2;
                end
                ACK2: begin
                    state          <= IDLE;
                    vector_valid_q <= 1'b0;
                end
                default: begin
                    state          <= IDLE;
                    vector_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.int_out      = int_q;
    assign bus.vector_idx   = vector_q;
    assign bus.vector_valid = vector_valid_q;
    assign bus.irr          = irr_q;
    assign bus.isr          = isr_q;

endmodule

// File: tb/tb_pic_irq_resolver.sv
// Directed self-checking bench for pic_irq_resolver with NUM_IRQ=8.
module tb_pic_irq_resolver;

`ifdef PIC_AEOI_EN
    localparam bit AEOI = 1'b1;
`else
    localparam bit AEOI = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;

    pic_irq_if #(.NUM_IRQ(8)) bus ();

    pic_irq_resolver #(.NUM_IRQ(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset            = 1'b1;
        bus.ir           = '0;
        bus.level_mode   = 1'b0;
        bus.mask         = '0;
        bus.rotate_mode  = 1'b0;
        bus.inta         = 1'b0;
        bus.eoi          = 1'b0;
        bus.eoi_specific = 1'b0;
        bus.eoi_idx      = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic ack_first();
        bus.inta = 1'b1;
        tick();
        bus.inta = 1'b0;
    endtask

    task automatic ack_second();
        bus.inta = 1'b1;
        tick();
        bus.inta = 1'b0;
        tick();
    endtask

    task automatic eoi_nonspec();
        bus.eoi = 1'b1;
        bus.eoi_specific = 1'b0;
        tick();
        bus.eoi = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (bus.irr !== 8'h00) begin n_err++; $display("FAIL rst_irr got %h want 00", bus.irr); end
        n_cmp++; if (bus.isr !== 8'h00) begin n_err++; $display("FAIL rst_isr got %h want 00", bus.isr); end
        n_cmp++; if (bus.int_out !== 1'b0) begin n_err++; $display("FAIL rst_int got %b want 0", bus.int_out); end
        n_cmp++; if (bus.vector_valid !== 1'b0) begin n_err++; $display("FAIL rst_vv got %b want 0", bus.vector_valid); end
        n_cmp++; if (dut.low_prio !== 3'd7) begin n_err++; $display("FAIL rst_low got %0d want 7", dut.low_prio); end
    endtask

    task automatic test_edge_ack();
        do_reset();
        bus.ir = 8'h28;
        tick();
        n_cmp++; if (bus.irr !== 8'h28) begin n_err++; $display("FAIL edge_irr got %h want 28", bus.irr); end
        n_cmp++; if (bus.int_out !== 1'b0) begin n_err++; $display("FAIL edge_int_early got %b want 0", bus.int_out); end
        tick();
        n_cmp++; if (bus.int_out !== 1'b1) begin n_err++; $display("FAIL edge_int got %b want 1", bus.int_out); end
        ack_first();
        n_cmp++; if (bus.vector_idx !== 3'd3) begin n_err++; $display("FAIL ack_vec got %0d want 3", bus.vector_idx); end
        n_cmp++; if (bus.vector_valid !== 1'b1) begin n_err++; $display("FAIL ack_vv got %b want 1", bus.vector_valid); end
        n_cmp++; if (bus.isr !== 8'h08) begin n_err++; $display("FAIL ack_isr got %h want 08", bus.isr); end
        n_cmp++; if (bus.irr !== 8'h20) begin n_err++; $display("FAIL ack_irr got %h want 20", bus.irr); end
        bus.inta = 1'b1;
        tick();
        bus.inta = 1'b0;
        n_cmp++; if (bus.vector_valid !== 1'b1) begin n_err++; $display("FAIL ack2_vv got %b want 1", bus.vector_valid); end
        tick();
        n_cmp++; if (bus.vector_valid !== 1'b0) begin n_err++; $display("FAIL idle_vv got %b want 0", bus.vector_valid); end
    endtask

    task automatic test_nesting();
        do_reset();
        bus.ir = 8'h08;
        tick(); tick();
        ack_first(); ack_second();
        bus.ir = 8'h28;
        tick(); tick();
        n_cmp++; if (bus.int_out !== AEOI) begin n_err++; $display("FAIL nest_low_int got %b want %b", bus.int_out, AEOI); end
        bus.ir = 8'h2A;
        tick(); tick();
        n_cmp++; if (bus.int_out !== 1'b1) begin n_err++; $display("FAIL nest_high_int got %b want 1", bus.int_out); end
        ack_first();
        n_cmp++; if (bus.vector_idx !== 3'd1) begin n_err++; $display("FAIL nest_vec got %0d want 1", bus.vector_idx); end
        n_cmp++; if (bus.isr !== (AEOI ? 8'h02 : 8'h0A)) begin n_err++; $display("FAIL nest_isr got %h want %h", bus.isr, AEOI ? 8'h02 : 8'h0A); end
        ack_second();
        eoi_nonspec();
        n_cmp++; if (bus.isr !== (AEOI ? 8'h00 : 8'h08)) begin n_err++; $display("FAIL nest_eoi_isr got %h want %h", bus.isr, AEOI ? 8'h00 : 8'h08); end
    endtask

    task automatic test_rotation();
        do_reset();
        bus.rotate_mode = 1'b1;
        bus.ir = 8'h81;
        tick(); tick();
        ack_first();
        n_cmp++; if (bus.vector_idx !== 3'd0) begin n_err++; $display("FAIL rot_vec0 got %0d want 0", bus.vector_idx); end
        ack_second();
        eoi_nonspec();
        n_cmp++; if (dut.low_prio !== 3'd0) begin n_err++; $display("FAIL rot_low got %0d want 0", dut.low_prio); end
        n_cmp++; if (bus.isr !== 8'h00) begin n_err++; $display("FAIL rot_isr0 got %h want 00", bus.isr); end
        ack_first();
        n_cmp++; if (bus.vector_idx !== 3'd7) begin n_err++; $display("FAIL rot_vec7 got %0d want 7", bus.vector_idx); end
        n_cmp++; if (bus.isr !== 8'h80) begin n_err++; $display("FAIL rot_isr7 got %h want 80", bus.isr); end
        ack_second();
        bus.ir = 8'h80;
        tick();
        bus.ir = 8'h81;
        tick();
        ack_first();
        n_cmp++; if (bus.vector_idx !== 3'd0) begin n_err++; $display("FAIL rot_vec0b got %0d want 0", bus.vector_idx); end
        n_cmp++; if (bus.isr !== (AEOI ? 8'h01 : 8'h81)) begin n_err++; $display("FAIL rot_isr0b got %h want %h", bus.isr, AEOI ? 8'h01 : 8'h81); end
        ack_second();
        n_cmp++; if (dut.low_prio !== (AEOI ? 3'd0 : 3'd0)) begin n_err++; $display("FAIL rot_low_end got %0d want 0", dut.low_prio); end
    endtask

    task automatic test_spurious();
        do_reset();
        bus.ir = 8'h04;
        tick();
        bus.ir = 8'h00;
        tick();
        n_cmp++; if (bus.irr !== 8'h00) begin n_err++; $display("FAIL spur_irr got %h want 00", bus.irr); end
        ack_first();
        n_cmp++; if (bus.vector_idx !== 3'd7) begin n_err++; $display("FAIL spur_vec got %0d want 7", bus.vector_idx); end
        n_cmp++; if (bus.isr !== 8'h00) begin n_err++; $display("FAIL spur_isr got %h want 00", bus.isr); end
        ack_second();
    endtask

    task automatic test_mask();
        do_reset();
        bus.mask = 8'h04;
        bus.ir = 8'h04;
        tick(); tick();
        n_cmp++; if (bus.irr !== 8'h04) begin n_err++; $display("FAIL mask_irr got %h want 04", bus.irr); end
        n_cmp++; if (bus.int_out !== 1'b0) begin n_err++; $display("FAIL mask_int got %b want 0", bus.int_out); end
        bus.mask = 8'h00;
        tick();
        n_cmp++; if (bus.int_out !== 1'b1) begin n_err++; $display("FAIL unmask_int got %b want 1", bus.int_out); end
    endtask

    task automatic test_level();
        do_reset();
        bus.level_mode = 1'b1;
        bus.ir = 8'h04;
        tick();
        n_cmp++; if (bus.irr !== 8'h04) begin n_err++; $display("FAIL lvl_irr got %h want 04", bus.irr); end
        bus.ir = 8'h00;
        tick();
        n_cmp++; if (bus.irr !== 8'h00) begin n_err++; $display("FAIL lvl_drop got %h want 00", bus.irr); end
        bus.ir = 8'h04;
        tick(); tick();
        ack_first();
        n_cmp++; if (bus.irr !== 8'h00) begin n_err++; $display("FAIL lvl_ackclr got %h want 00", bus.irr); end
        n_cmp++; if (bus.vector_idx !== 3'd2) begin n_err++; $display("FAIL lvl_vec got %0d want 2", bus.vector_idx); end
        tick();
        n_cmp++; if (bus.irr !== 8'h04) begin n_err++; $display("FAIL lvl_refill got %h want 04", bus.irr); end
        ack_second();
    endtask

    task automatic test_back_to_back();
        do_reset();
        bus.ir = 8'h08;
        tick(); tick();
        ack_first(); ack_second();
        bus.ir = 8'h0A;
        tick(); tick();
        bus.inta = 1'b1;
        bus.eoi = 1'b1;
        bus.eoi_specific = 1'b1;
        bus.eoi_idx = 3'd3;
        tick();
        bus.inta = 1'b0;
        bus.eoi = 1'b0;
        n_cmp++; if (bus.isr !== 8'h02) begin n_err++; $display("FAIL b2b_isr got %h want 02", bus.isr); end
        n_cmp++; if (bus.vector_idx !== 3'd1) begin n_err++; $display("FAIL b2b_vec got %0d want 1", bus.vector_idx); end
        ack_second();
        bus.ir = 8'h00;
        tick();
        bus.ir = 8'h04;
        tick();
        bus.inta = 1'b1;
        bus.eoi = 1'b1;
        bus.eoi_specific = 1'b1;
        bus.eoi_idx = 3'd2;
        tick();
        bus.inta = 1'b0;
        bus.eoi = 1'b0;
        n_cmp++; if (bus.isr !== (AEOI ? 8'h04 : 8'h06)) begin n_err++; $display("FAIL setwins_isr got %h want %h", bus.isr, AEOI ? 8'h04 : 8'h06); end
        ack_second();
    endtask

    task automatic test_reset_in_ack();
        do_reset();
        bus.ir = 8'h01;
        tick(); tick();
        ack_first();
        n_cmp++; if (bus.vector_valid !== 1'b1) begin n_err++; $display("FAIL rack_vv_pre got %b want 1", bus.vector_valid); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_cmp++; if (bus.vector_valid !== 1'b0) begin n_err++; $display("FAIL rack_vv got %b want 0", bus.vector_valid); end
        n_cmp++; if (bus.isr !== 8'h00) begin n_err++; $display("FAIL rack_isr got %h want 00", bus.isr); end
        n_cmp++; if (dut.low_prio !== 3'd7) begin n_err++; $display("FAIL rack_low got %0d want 7", dut.low_prio); end
        tick();
        ack_first();
        n_cmp++; if (bus.isr !== 8'h01) begin n_err++; $display("FAIL rack_reack_isr got %h want 01", bus.isr); end
        ack_second();
        n_cmp++; if (bus.isr !== (AEOI ? 8'h00 : 8'h01)) begin n_err++; $display("FAIL aeoi_isr got %h want %h", bus.isr, AEOI ? 8'h00 : 8'h01); end
    endtask

    initial begin
        test_reset();
        test_edge_ack();
        test_nesting();
        test_rotation();
        test_spurious();
        test_mask();
        test_level();
        test_back_to_back();
        test_reset_in_ack();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
